// File: rtl/teclado_emulador.sv
// Keypad contact emulator: presses a requested key on a 4x4 matrix,
// with optional contact bounce at press and release.
module teclado_emulador #(
    parameter int unsigned HOLD_CYCLES   = 64,
    parameter int unsigned GAP_CYCLES    = 64,
    parameter int unsigned BOUNCE_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] columnas,
    output logic [3:0] filas,
    input  logic       req_valid,
    input  logic [3:0] req_key,
    output logic       req_ready,
    output logic       busy,
    output logic       key_down,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HOLD,
        BOUNCE_OUT,
        GAP
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] BOUNCE_LAST =
        (BOUNCE_CYCLES > 0) ? 16'(BOUNCE_CYCLES - 1) : 16'd0;
    localparam bit HAS_BOUNCE = (BOUNCE_CYCLES > 0);
    localparam bit GAP_ONE    = (GAP_CYCLES == 1);

    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  key;
    logic [1:0]  row;
    logic [1:0]  col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            key      <= 4'd0;
            key_down <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    cnt  <= 16'd0;
                    if (req_valid) begin
                        key      <= req_key;
                        key_down <= 1'b1;
                        state    <= HAS_BOUNCE ? BOUNCE_IN : HOLD;
                    end
                end
                BOUNCE_IN: begin
                    if (cnt == BOUNCE_LAST) begin
                        state    <= HOLD;
                        cnt      <= 16'd0;
                        key_down <= 1'b1;
                    end else begin
                        cnt      <= cnt + 16'd1;
                        key_down <= ~key_down;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt      <= 16'd0;
                        key_down <= 1'b0;
                        if (HAS_BOUNCE) begin
                            state <= BOUNCE_OUT;
                        end else begin
                            state <= GAP;
                            done  <= GAP_ONE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                BOUNCE_OUT: begin
                    if (cnt == BOUNCE_LAST) begin
                        state    <= GAP;
                        cnt      <= 16'd0;
                        key_down <= 1'b0;
                        done     <= GAP_ONE;
                    end else begin
                        cnt      <= cnt + 16'd1;
                        key_down <= ~key_down;
                    end
                end
                GAP: begin
                    // done is raised one edge early so it is high on the last gap cycle
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        cnt   <= 16'd0;
                        done  <= 1'b0;
                    end else begin
                        cnt  <= cnt + 16'd1;
                        done <= ((cnt + 16'd1) == GAP_LAST);
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= 16'd0;
                    key_down <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        row = 2'd0;
        col = 2'd0;
        unique case (key)
            4'h1: begin row = 2'd0; col = 2'd0; end
            4'h4: begin row = 2'd1; col = 2'd0; end
            4'h7: begin row = 2'd2; col = 2'd0; end
            4'hE: begin row = 2'd3; col = 2'd0; end
            4'h2: begin row = 2'd0; col = 2'd1; end
            4'h5: begin row = 2'd1; col = 2'd1; end
            4'h8: begin row = 2'd2; col = 2'd1; end
            4'h0: begin row = 2'd3; col = 2'd1; end
            4'h3: begin row = 2'd0; col = 2'd2; end
            4'h6: begin row = 2'd1; col = 2'd2; end
            4'h9: begin row = 2'd2; col = 2'd2; end
            4'hF: begin row = 2'd3; col = 2'd2; end
            4'hA: begin row = 2'd0; col = 2'd3; end
            4'hB: begin row = 2'd1; col = 2'd3; end
            4'hC: begin row = 2'd2; col = 2'd3; end
            4'hD: begin row = 2'd3; col = 2'd3; end
            default: begin row = 2'd0; col = 2'd0; end
        endcase
    end

    // Same-cycle row return so the scanner sees a consistent pair
    always_comb begin
        filas = 4'hF;
        if (key_down && !columnas[2'd3 - col]) begin
            filas[2'd3 - row] = 1'b0;
        end
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_teclado_emulador.sv
// Bench for teclado_emulador: two parameterisations, directed scenarios
// plus randomized traffic checked against a sequence-level model.
module tb_teclado_emulador;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [3:0] col [2];
    logic [3:0] fil [2];
    logic       rv  [2];
    logic [3:0] rk  [2];
    logic       rdy [2];
    logic       bsy [2];
    logic       kd  [2];
    logic       dn  [2];

    localparam int P_BI   [2] = '{0, 3};
    localparam int P_HOLD [2] = '{4, 2};
    localparam int P_GAP  [2] = '{2, 2};

    // Key map from the keypad layout, indexed [c*4 + r]
    localparam logic [3:0] MAP [16] = '{
        4'h1, 4'h4, 4'h7, 4'hE,
        4'h2, 4'h5, 4'h8, 4'h0,
        4'h3, 4'h6, 4'h9, 4'hF,
        4'hA, 4'hB, 4'hC, 4'hD
    };
    localparam logic [3:0] ROT [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    teclado_emulador #(
        .HOLD_CYCLES(4), .GAP_CYCLES(2), .BOUNCE_CYCLES(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .columnas(col[0]), .filas(fil[0]),
        .req_valid(rv[0]), .req_key(rk[0]), .req_ready(rdy[0]),
        .busy(bsy[0]), .key_down(kd[0]), .done(dn[0])
    );

    teclado_emulador #(
        .HOLD_CYCLES(2), .GAP_CYCLES(2), .BOUNCE_CYCLES(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .columnas(col[1]), .filas(fil[1]),
        .req_valid(rv[1]), .req_key(rk[1]), .req_ready(rdy[1]),
        .busy(bsy[1]), .key_down(kd[1]), .done(dn[1])
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request plays a fixed per-cycle contact sequence
    bit         m_busy [2] = '{0, 0};
    int         m_idx  [2] = '{0, 0};
    logic [3:0] m_key  [2] = '{4'd0, 4'd0};

    function automatic int seq_len(int u);
        return 2 * P_BI[u] + P_HOLD[u] + P_GAP[u];
    endfunction

    function automatic logic exp_kd(int u, int idx);
        int i;
        i = idx;
        if (i < P_BI[u]) return (i % 2 == 0);
        i -= P_BI[u];
        if (i < P_HOLD[u]) return 1'b1;
        i -= P_HOLD[u];
        if (i < P_BI[u]) return (i % 2 == 1);
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_filas(int u);
        logic [3:0] f;
        int c;
        int r;
        f = 4'hF;
        if (m_busy[u] && exp_kd(u, m_idx[u])) begin
            for (int i = 0; i < 16; i++) begin
                if (MAP[i] == m_key[u]) begin
                    c = i / 4;
                    r = i % 4;
                    if (!col[u][3 - c]) f[3 - r] = 1'b0;
                end
            end
        end
        return f;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                m_busy[u] = 1'b0;
                m_idx[u]  = 0;
                m_key[u]  = 4'd0;
            end else if (m_busy[u]) begin
                m_idx[u]++;
                if (m_idx[u] == seq_len(u)) m_busy[u] = 1'b0;
            end else if (rv[u]) begin
                m_busy[u] = 1'b1;
                m_idx[u]  = 0;
                m_key[u]  = rk[u];
            end
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d_ready", u), 32'(rdy[u]), 32'(!m_busy[u]));
            chk($sformatf("u%0d_busy", u), 32'(bsy[u]), 32'(m_busy[u]));
            chk($sformatf("u%0d_key_down", u), 32'(kd[u]),
                32'(m_busy[u] && exp_kd(u, m_idx[u])));
            chk($sformatf("u%0d_done", u), 32'(dn[u]),
                32'(m_busy[u] && m_idx[u] == seq_len(u) - 1));
            chk($sformatf("u%0d_filas", u), 32'(fil[u]), 32'(exp_filas(u)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [15:0] m_c;
    logic [15:0] m_d;

    initial begin
        for (int u = 0; u < 2; u++) begin
            col[u] = 4'hF;
            rv[u]  = 1'b0;
            rk[u]  = 4'd0;
        end
        #3;
        for (int u = 0; u < 2; u++) begin
            chk("reset_filas", 32'(fil[u]), 32'hF);
            chk("reset_ready", 32'(rdy[u]), 32'd1);
            chk("reset_key_down", 32'(kd[u]), 32'd0);
        end
        step();
        step();
        rst_n = 1'b1;
        step();

        // Key 5 against a rotating column drive
        rv[0] = 1'b1;
        rk[0] = 4'h5;
        step();
        rv[0] = 1'b0;
        m_a = '0;
        m_b = '0;
        for (int k = 1; k <= 8; k++) begin
            col[0] = ROT[(k - 1) % 4];
            @(negedge clk);
            m_a[k - 1] = (fil[0] == 4'b1011);
            m_b[k - 1] = dn[0];
            step();
        end
        chk("t1_row_hits", 32'(m_a[7:0]), 32'b00000010);
        chk("t1_done_at", 32'(m_b[7:0]), 32'b00100000);

        // Bounce profile on key 1, column 0 driven
        col[1] = 4'b0111;
        rv[1]  = 1'b1;
        rk[1]  = 4'h1;
        step();
        rv[1] = 1'b0;
        m_a = '0;
        m_b = '0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            m_a[k - 1] = fil[1][3];
            m_b[k - 1] = dn[1];
            step();
        end
        chk("t2_bounce_seq", 32'(m_a[10:0]), 32'b11110100010);
        chk("t2_done_at", 32'(m_b[10:0]), 32'b01000000000);

        // Request while busy is dropped
        col[0] = 4'b0000;
        rv[0]  = 1'b1;
        rk[0]  = 4'h2;
        step();
        rv[0] = 1'b0;
        m_a = '0;
        m_b = '0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) begin
                rv[0] = 1'b1;
                rk[0] = 4'h9;
            end
            if (k == 3) rv[0] = 1'b0;
            @(negedge clk);
            m_a[k - 1] = (fil[0] == 4'b0111);
            m_b[k - 1] = (fil[0] == 4'b1101);
            step();
        end
        chk("t3_key2_rows", 32'(m_a[7:0]), 32'b00001111);
        chk("t3_key9_rows", 32'(m_b[7:0]), 32'd0);
        chk("t3_idle_after", 32'(bsy[0]), 32'd0);
        rv[0] = 1'b1;
        rk[0] = 4'h9;
        step();
        rv[0] = 1'b0;
        m_b = '0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            m_b[k - 1] = (fil[0] == 4'b1101);
            step();
        end
        chk("t3_key9_repress", 32'(m_b[6:0]), 32'b0001111);

        // Reset dropped in the second hold cycle
        rv[0] = 1'b1;
        rk[0] = 4'h7;
        step();
        rv[0] = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_async_filas", 32'(fil[0]), 32'hF);
        chk("t4_async_kd", 32'(kd[0]), 32'd0);
        chk("t4_async_ready", 32'(rdy[0]), 32'd1);
        step();
        rst_n = 1'b1;
        m_b = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            m_b[k - 1] = dn[0];
            step();
        end
        chk("t4_no_done", 32'(m_b[3:0]), 32'd0);
        rv[0] = 1'b1;
        rk[0] = 4'h0;
        step();
        rv[0] = 1'b0;
        m_a = '0;
        m_b = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            m_a[k - 1] = (fil[0] == 4'b1110);
            m_b[k - 1] = dn[0];
            step();
        end
        chk("t4_key0_rows", 32'(m_a[7:0]), 32'b00001111);
        chk("t4_key0_done", 32'(m_b[7:0]), 32'b00100000);

        // Back-to-back keys 3 then E with req_valid held
        rv[0] = 1'b1;
        rk[0] = 4'h3;
        step();
        rk[0] = 4'hE;
        m_a = '0;
        m_b = '0;
        m_c = '0;
        m_d = '0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 8) rv[0] = 1'b0;
            @(negedge clk);
            m_a[k - 1] = rdy[0];
            m_b[k - 1] = dn[0];
            m_c[k - 1] = (fil[0] == 4'b0111);
            m_d[k - 1] = (fil[0] == 4'b1110);
            step();
        end
        chk("t5_ready_at", 32'(m_a[13:0]), 32'b10000001000000);
        chk("t5_done_at", 32'(m_b[13:0]), 32'b01000000100000);
        chk("t5_key3_rows", 32'(m_c[13:0]), 32'b00000000001111);
        chk("t5_keyE_rows", 32'(m_d[13:0]), 32'b00011110000000);

        // Randomized traffic, checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            for (int u = 0; u < 2; u++) begin
                rv[u]  = ($urandom_range(0, 3) == 0);
                rk[u]  = 4'($urandom);
                col[u] = 4'($urandom);
            end
            rst_n = ($urandom_range(0, 499) != 0);
            step();
        end
        rst_n = 1'b1;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        repeat (30) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/teclado_emulador.md
TECLADO_EMULADOR -- requirements
Module: teclado_emulador

Interface
REQ-001 HOLD_CYCLES, default 64: cycles the contact stays closed in the stable-press phase; legal range 1..65535.
REQ-002 GAP_CYCLES, default 64: cycles the contact stays open after release before the next request is accepted; legal range 1..65535.
REQ-003 BOUNCE_CYCLES, default 0: length of each bounce phase, both at press and at release; 0 disables bouncing; legal range 0..65535.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 columnas  input  4  active-low column drive from the scanner.
REQ-007 filas  output  4  active-low row return to the scanner.
REQ-008 req_valid  input  1  key-press request strobe.
REQ-009 req_key  input  4  requested key code, using the same code map as the scanner.
REQ-010 req_ready  output  1  high when a request can be accepted.
REQ-011 busy  output  1  high while a press/release sequence is in progress.
REQ-012 key_down  output  1  current contact state; 1 = closed.
REQ-013 done  output  1  one-cycle pulse when the gap phase ends.

Function
REQ-014 Key map (column index c drives columnas[3-c]; row index r returns on filas[3-r]):
- c0: r0..r3 = 1, 4, 7, E.
- c1: r0..r3 = 2, 5, 8, 0.
- c2: r0..r3 = 3, 6, 9, F.
- c3: r0..r3 = A, B, C, D.
REQ-015 filas SHALL be combinational from columnas and the registered state, with zero-cycle latency, so the scanner decodes a consistent row/column pair in the same cycle.
REQ-016 filas[3-r] SHALL be 0 only when key_down=1 AND columnas[3-c]=0 for the latched key (r,c); all other filas bits SHALL be 1.
REQ-017 If more than one columnas bit is 0, REQ-016 still applies per bit; no error is flagged.
REQ-018 FSM states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
REQ-019 req_ready SHALL be 1 only in IDLE; busy SHALL equal NOT req_ready.
REQ-020 A request is accepted when req_valid=1 and req_ready=1. On the accepting edge, req_key is latched and decoded to (r,c), and the FSM goes to BOUNCE_IN if BOUNCE_CYCLES>0, else to HOLD.
REQ-021 req_valid while busy SHALL be ignored; the in-flight sequence SHALL NOT change.
REQ-022 BOUNCE_IN lasts BOUNCE_CYCLES cycles:
- key_down toggles every cycle, starting at 1 on the first cycle.
- key_down is forced to 1 on exit to HOLD.
REQ-023 HOLD lasts exactly HOLD_CYCLES cycles with key_down=1, then goes to BOUNCE_OUT if BOUNCE_CYCLES>0, else to GAP.
REQ-024 BOUNCE_OUT lasts BOUNCE_CYCLES cycles:
- key_down toggles every cycle, starting at 0 on the first cycle.
- key_down is forced to 0 on exit to GAP.
REQ-025 GAP lasts exactly GAP_CYCLES cycles with key_down=0.
REQ-026 On the last GAP cycle, done SHALL be 1 for exactly one cycle, and the FSM returns to IDLE on the next edge.
REQ-027 Phase counters SHALL be 16 bits; each counts 0..N-1 and reloads at 0 on every state entry; no wrap within a phase.
REQ-028 A request arriving in the cycle after done SHALL be accepted, giving a back-to-back throughput of BI+HOLD+BO+GAP+1 cycles per key (BI = bounce-in cycles, BO = bounce-out cycles).
REQ-029 Code F denotes '#' and is pressed like any other key; the emulator has no "no key" request.

Reset
REQ-030 rst_n=0 SHALL asynchronously force:
- state = IDLE, key_down = 0, done = 0, busy = 0, req_ready = 1;
- latched key = 0, counters = 0.
As a result, filas = 1111 immediately, with no clock required.
REQ-031 A reset asserted mid-sequence SHALL abort the press with no done pulse; the first request after rst_n rises SHALL be accepted normally.

Verification
REQ-032 HOLD=4, GAP=2, BOUNCE=0; request key 5 while columnas cycles 0111→1011→1101→1110:
- filas=1011 only while columnas=1011 during the 4 HOLD cycles; otherwise 1111;
- done pulses 6 cycles after acceptance.
REQ-033 Request D, then pair the emulator with the scanner (SCAN_DIV=1) with HOLD=16: scanner boton reads D at least once, and F when no contact.
REQ-034 BOUNCE=3, HOLD=2, GAP=2, key 1, columnas fixed 0111 → filas[3] sequence 0,1,0,0,0,1,0,1,1,1 then done.
REQ-035 req_valid asserted with key 9 during HOLD of key 2 → ignored; only key 2 is observed on filas; key 9 is accepted after done only if re-presented.
REQ-036 rst_n dropped in the 2nd HOLD cycle → filas=1111, key_down=0, req_ready=1 asynchronously; no done pulse; a new request for key 0 after reset completes normally.
REQ-037 Back-to-back requests for keys 3 then E with req_valid held high → accepted on consecutive ready cycles; total 2×(HOLD+GAP+1) cycles; done pulses twice.
